// File: rtl/ln_ctrl_pkg.sv
// Shared types and defaults for the natural-log core sharing controller.
// Holds the FSM encoding, default widths and the timeout counter width helper.
package ln_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_LAUNCH,
      S_WAIT,
      S_DONE
   } state_t;

   localparam int DEF_X_W     = 16;
   localparam int DEF_R_W     = 18;
   localparam int DEF_TIMEOUT = 64;

   // Width of the WAIT timeout counter; never narrower than one bit.
   function automatic int to_w(input int timeout);
      return (timeout > 2) ? $clog2(timeout) : 1;
   endfunction

   localparam int DEF_TO_W = to_w(DEF_TIMEOUT);

endpackage

// File: rtl/ln_share_ctrl_rr_pick.sv
// Combinational round-robin select: the first requester found after ptr,
// wrapping modulo N_REQ, wins.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic             any,
   output logic [PTR_W-1:0] win
);

   logic [PTR_W-1:0] cand [N_REQ];
   logic [N_REQ-1:0] hit;

   // Candidate gi is the requester at distance gi+1 after the pointer.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [PTR_W:0] sum;
      assign sum       = {1'b0, ptr} + (PTR_W+1)'(gi + 1);
      assign cand[gi]  = (sum >= (PTR_W+1)'(N_REQ)) ? PTR_W'(sum - (PTR_W+1)'(N_REQ))
                                                     : sum[PTR_W-1:0];
      assign hit[gi]   = req[cand[gi]];
   end

   always_comb begin
      any = 1'b0;
      win = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (hit[i]) begin
            any = 1'b1;
            win = cand[i];
         end
      end
   end

endmodule

// File: rtl/ln_share_ctrl.sv
// Shares one natural-log core between N_REQ requesters: round-robin grant,
// core clear, launch, bounded wait for Ready, then a one-hot completion.
module ln_share_ctrl
   import ln_ctrl_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int X_W     = DEF_X_W,
   parameter int R_W     = DEF_R_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*X_W-1:0]   req_x,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REQ-1:0]       done,
   output logic [R_W-1:0]         res,
   output logic                   err,
   output logic                   core_rst,
   output logic                   core_start,
   output logic [X_W-1:0]         core_x,
   input  logic                   core_ready,
   input  logic [R_W-1:0]         core_r
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int TO_W  = to_w(TIMEOUT);

   state_t             state_q;
   logic [PTR_W-1:0]   ptr_q;
   logic [PTR_W-1:0]   win_q;
   logic [X_W-1:0]     x_q;
   logic [TO_W-1:0]    cnt_q;
   logic               hold_q;
   logic [R_W-1:0]     res_q;
   logic               err_q;
   logic [N_REQ-1:0]   gnt_q;
   logic [N_REQ-1:0]   done_q;
   logic               start_q;
   logic [X_W-1:0]     core_x_q;

   logic               pick_any;
   logic [PTR_W-1:0]   pick_idx;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req (req),
      .ptr (ptr_q),
      .any (pick_any),
      .win (pick_idx)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         ptr_q    <= PTR_W'(N_REQ - 1);
         win_q    <= '0;
         x_q      <= '0;
         cnt_q    <= '0;
         hold_q   <= 1'b0;
         res_q    <= '0;
         err_q    <= 1'b0;
         gnt_q    <= '0;
         done_q   <= '0;
         start_q  <= 1'b0;
         core_x_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pick_any) begin
                  win_q   <= pick_idx;
                  ptr_q   <= pick_idx;
                  x_q     <= req_x[pick_idx*X_W +: X_W];
                  gnt_q   <= N_REQ'(1) << pick_idx;
                  state_q <= S_CLR;
               end
            end
            S_CLR: begin
               gnt_q    <= '0;
               start_q  <= 1'b1;
               core_x_q <= x_q;
               state_q  <= S_LAUNCH;
            end
            S_LAUNCH: begin
               start_q <= 1'b0;
               cnt_q   <= '0;
               hold_q  <= 1'b1;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (core_ready) begin
                  res_q    <= core_r;
                  err_q    <= 1'b0;
                  done_q   <= N_REQ'(1) << win_q;
                  core_x_q <= '0;
                  state_q  <= S_DONE;
               end else if (hold_q) begin
                  // Counting starts one WAIT cycle late so the error
                  // completion lands TIMEOUT+3 cycles after the grant.
                  hold_q <= 1'b0;
               end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                  res_q    <= '0;
                  err_q    <= 1'b1;
                  done_q   <= N_REQ'(1) << win_q;
                  core_x_q <= '0;
                  state_q  <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DONE: begin
               done_q  <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign gnt        = gnt_q;
   assign done       = done_q;
   assign res        = (|done_q) ? res_q : '0;
   assign err        = (|done_q) & err_q;
   assign core_start = start_q;
   assign core_x     = core_x_q;
   // The core is held cleared for as long as the controller is in reset.
   assign core_rst   = ~rst | (state_q == S_CLR);

endmodule

// File: doc/ln_share_ctrl.md
# ln_share_ctrl

Controller that shares one natural-log core (`part_Ln_TOP`) between `N_REQ` requesters. It arbitrates round-robin and clears the core before every operation. It then launches the core, waits for its ready with a timeout, and returns the result to the winning requester. It sits between the requesting datapaths and the single Ln instance, and owns that instance's `rst`, `start` and `Xbus` pins.

## Interface
- `N_REQ`, 4: number of requesters (2..8)
- `X_W`, 16: operand width (UQ0.16, 16'h8000 = 0.5)
- `R_W`, 18: result width of the core's `RBUS`
- `TIMEOUT`, 64: maximum WAIT cycles before an error completion
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous reset, active-low
- `req` in N_REQ: request levels, one bit per requester
- `req_x` in N_REQ*X_W: operands; requester i uses bits `[i*X_W +: X_W]`
- `gnt` out N_REQ: one-hot, one-cycle pulse when operand i is latched
- `done` out N_REQ: one-hot, one-cycle pulse when the result for requester i is valid
- `res` out R_W: result, valid only while `done` is nonzero
- `err` out 1: qualifies `done`; 1 = timeout, and `res` = 0
- `core_rst` out 1: core reset, active-high
- `core_start` out 1: core start pulse
- `core_x` out X_W: core operand
- `core_ready` in 1: core `Ready`
- `core_r` in R_W: core `RBUS`

## Operation
- FSM states:
  - IDLE: if any `req` bit is high, pick winner w, latch `req_x[w]` into `x_q`, update pointer to w, go to CLR.
  - CLR: `core_rst`=1, `gnt[w]`=1. Go to LAUNCH.
  - LAUNCH: `core_start`=1, `core_x`=`x_q`. Clear the timeout counter. Go to WAIT.
  - WAIT: `core_x`=`x_q`.
    - If `core_ready`=1, capture `core_r` into `res_q`, set `err_q`=0, go to DONE.
    - Else, if the counter equals TIMEOUT-1, set `res_q`=0 and `err_q`=1, go to DONE.
    - Else increment the counter.
  - DONE: `done[w]`=1, `res`=`res_q`, `err`=`err_q`. Go to IDLE.
- Round-robin: search starts at (pointer+1) mod N_REQ. Reset value of the pointer is N_REQ-1, so requester 0 wins first.
- `req` is sampled only in IDLE.
  - A requester may drop `req` before its `gnt` (withdrawal); it is not served.
  - A requester must hold `req_x` stable until its `gnt` pulse.
  - A requester must drop `req` in the cycle after `gnt`, or it re-enters arbitration.
- `core_ready` is ignored in CLR and LAUNCH. A stale Ready from the previous operation is never taken as a completion.
- Reset values: all outputs 0 except `core_rst`.
  - `core_rst` = ~`rst` OR (state==CLR). The core is held in reset while `rst` is low.
  - State = IDLE, pointer = N_REQ-1, counter = 0.
- Reset mid-operation: the operation in flight is abandoned with no `done` for it. `gnt`/`done` fall to 0 asynchronously.

## Timing
- IDLE sees `req` at cycle t: `gnt` and `core_rst` at t+1, `core_start` at t+2, first WAIT at t+3.
- `core_ready` sampled high at cycle k: `done`/`res` at k+1, IDLE at k+2. The earliest next `gnt` is k+3.
- Timeout: `done` with `err`=1 exactly TIMEOUT+3 cycles after `gnt`, with `core_ready` held low throughout.
- At most one operation is in flight. `gnt` and `done` are never both nonzero in the same cycle.

## Structure
- Package `ln_ctrl_pkg`:
  - state encoding (IDLE, CLR, LAUNCH, WAIT, DONE)
  - default widths: X_W, R_W
  - `TO_W` = clog2(TIMEOUT)
- Sub-module `rr_pick`: combinational round-robin select.
  - Inputs: `req[N_REQ]`, `ptr`.
  - Outputs: `any`, winner index.

## Test plan
Bench uses a stub core: after `core_start`, it asserts Ready for 1 cycle at a programmable latency L, with `core_r` = {2'b10, `core_x`}. `core_rst` clears its Ready.
- Single request: `req`=4'b0001, `req_x[0]`=16'h8000, L=20.
  - `gnt[0]` at t+1; `done[0]` at t+23.
  - `res`=18'h28000, `err`=0.
- All four request at once, operands 16'h8000, 16'h0000, 16'h4000, 16'hC000.
  - Served in order 0,1,2,3, each `gnt` exactly once.
  - Each result matches its own operand.
- Fairness: requesters 1 and 3 re-request continuously.
  - Grants alternate 1,3,1,3.
  - Requester 0 raised mid-sequence is granted within 2 operations.
- Timeout: stub never asserts Ready.
  - `done` with `err`=1 and `res`=0 at `gnt`+67.
  - The next request proceeds normally.
- Stale Ready: stub holds Ready=1 until `core_rst`.
  - Completion occurs only at the fresh Ready, L cycles after `core_start`.
- Reset in WAIT: `rst` low for 2 cycles.
  - Outputs 0 and `core_rst`=1 immediately; no `done` for the aborted operation.
  - After release, requester 0 has priority.
